xnorfa_accumulator: RTL

XNORFA_ACCUMULATOR -- requirements
Module: xnorfa_accumulator

---
 rtl/xnorfa_pkg.sv | 15 +
 rtl/xnorfa_sat_add.sv | 25 ++
 rtl/xnorfa_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/xnorfa_pkg.sv
// Shared definitions for the XNOR-full-adder popcount accumulator:
// FSM state encoding, partial-count width and default parameter values.
package xnorfa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int M_W             = 2;
    localparam int DEFAULT_ACC_W   = 10;
    localparam int DEFAULT_MAX_LEN = 256;

endpackage

// File: rtl/xnorfa_sat_add.sv
// ACC_W-wide accumulator adder for a 2-bit partial count with overflow flag.
// Define XNORFA_ACC_SAT_EN to saturate on overflow; otherwise the sum wraps.
module xnorfa_sat_add
    import xnorfa_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [M_W-1:0]   b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] wide;

    assign wide = {1'b0, a} + {{(ACC_W + 1 - M_W){1'b0}}, b};
    assign ovf  = wide[ACC_W];

`ifdef XNORFA_ACC_SAT_EN
    assign sum = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/xnorfa_accumulator.sv
// Streaming popcount accumulator with binarisation and a held result handshake.
// Overflow mode selected by XNORFA_ACC_SAT_EN (saturate) vs. default (wrap).
module xnorfa_accumulator
    import xnorfa_pkg::*;
#(
    parameter int ACC_W   = DEFAULT_ACC_W,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [M_W-1:0]   in_m,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_bit,
    output logic             out_err
);

    localparam int               CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_bit_q, out_bit_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             beat;
    logic             load_out;

    xnorfa_sat_add #(.ACC_W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (in_m),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready  = (state_q != DONE);
    assign beat      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_bit   = out_bit_q;
    assign out_err   = out_err_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        thr_d       = thr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_sum_d   = out_sum_q;
        out_bit_d   = out_bit_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        load_out    = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d    = {{(ACC_W - M_W){1'b0}}, in_m};
                    thr_d    = thresh;
                    cnt_d    = CNT_W'(1);
                    err_d    = 1'b0;
                    state_d  = ACC;
                    load_out = in_last;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d    = add_sum;
                    // Count parks at MAX_LEN; every beat beyond it is already an error.
                    cnt_d    = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    err_d    = err_q | add_ovf | (cnt_q >= CNT_MAX);
                    load_out = in_last;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result registers capture the post-beat totals on the same edge as the last beat.
        if (load_out) begin
            state_d     = DONE;
            out_sum_d   = acc_d;
            out_bit_d   = (acc_d >= thr_d);
            out_err_d   = err_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            thr_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_sum_q   <= '0;
            out_bit_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            thr_q       <= thr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_sum_q   <= out_sum_d;
            out_bit_q   <= out_bit_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
